// File: rtl/cdc_pkg.sv
// Shared types and helpers for the reset release sequencer.
package cdc_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_RDY = 2'd1,
    SEQ      = 2'd2,
    DONE     = 2'd3
  } rst_seq_state_e;

  // Counter width large enough to hold the largest terminal count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on async_clr.
module cdc_bit_sync #(
  parameter int unsigned SYNC_FF = 2
) (
  input  logic clk,
  input  logic async_clr,
  input  logic i_d,
  output logic o_q
);

  (* async_reg = "true" *) logic [SYNC_FF-1:0] r_sync;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge async_clr) begin
    if (async_clr) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_FF-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_FF-1];

endmodule

// File: rtl/cdc_rst_sequencer.sv
// Reset release sequencer: holds reset for MIN_ASSERT cycles, waits for ready (PLL lock),
// then releases N_STAGE reset domains in index order, STAGE_DLY cycles apart.
// Optional WAIT_RDY timeout enabled by defining CDC_RST_SEQ_TIMEOUT_EN.
module cdc_rst_sequencer
  import cdc_pkg::*;
#(
  parameter int unsigned N_STAGE       = 3,
  parameter int unsigned STAGE_DLY     = 16,
  parameter int unsigned MIN_ASSERT    = 8,
  parameter int unsigned READY_SYNC_FF = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic               clk,
  input  logic               async_clr,
  input  logic               ready_async,
  input  logic               sw_rst_req,
  output logic [N_STAGE-1:0] rst_out,
  output logic               done,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned CW = cnt_width(MIN_ASSERT, STAGE_DLY, TIMEOUT);
  localparam int unsigned IW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_STAGE - 1);
`ifdef CDC_RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
`endif

  rst_seq_state_e     r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic [N_STAGE-1:0] r_rst, w_rst_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_done, r_busy;
  logic               w_ready_sync;
  logic               w_ready_lost;

  cdc_bit_sync #(
    .SYNC_FF (READY_SYNC_FF)
  ) u_ready_sync (
    .clk       (clk),
    .async_clr (async_clr),
    .i_d       (ready_async),
    .o_q       (w_ready_sync)
  );

`ifdef CDC_RST_SEQ_TIMEOUT_EN
  // Once timed out we run without ready, so its absence must not restart the sequence.
  assign w_ready_lost = ~w_ready_sync & ~r_timeout;
`else
  assign w_ready_lost = ~w_ready_sync;
`endif

  // Next-state, counter, stage index and reset vector.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_rst_nxt     = r_rst;
    w_timeout_nxt = r_timeout;
    if (sw_rst_req) w_timeout_nxt = 1'b0;
    unique case (r_state)
      HOLD: begin
        w_rst_nxt = '1;
        if (sw_rst_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = WAIT_RDY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      WAIT_RDY: begin
        if (sw_rst_req) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
        end else if (w_ready_sync) begin
          w_state_nxt = SEQ;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
`ifdef CDC_RST_SEQ_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = SEQ;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      SEQ: begin
        if (sw_rst_req || w_ready_lost) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
        end else if (r_cnt == STAGE_LAST) begin
          // Shifting left clears the lowest still-asserted bit, preserving release order.
          w_rst_nxt = r_rst << 1;
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + IW'(1);
          if (r_idx == IDX_LAST) w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        if (sw_rst_req || w_ready_lost) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
        end
      end
      default: begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_rst_nxt   = '1;
      end
    endcase
  end

  // State and registered outputs; done/busy derive from next state so they align with it.
  always_ff @(posedge clk or posedge async_clr) begin
    if (async_clr) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst     <= '1;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst     <= w_rst_nxt;
      r_timeout <= w_timeout_nxt;
      r_done    <= (w_state_nxt == DONE);
      r_busy    <= (w_state_nxt != DONE);
    end
  end

  assign rst_out = r_rst;
  assign done    = r_done;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_cdc_rst_sequencer.sv
// Scoreboard bench for cdc_rst_sequencer: expected output transitions (edge number and value)
// are queued by the stimulus; a negedge monitor pops one on every observed output change.
module tb_cdc_rst_sequencer;

`ifdef CDC_RST_SEQ_TIMEOUT_EN
  localparam int unsigned TO_CYC = 32;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic       clk = 1'b0;
  logic       async_clr = 1'b0;
  logic       ready_async = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_out;
  logic       done, busy, timeout;

  cdc_rst_sequencer #(
    .N_STAGE       (3),
    .STAGE_DLY     (16),
    .MIN_ASSERT    (8),
    .READY_SYNC_FF (2),
    .TIMEOUT       (TO_CYC)
  ) dut (
    .clk         (clk),
    .async_clr   (async_clr),
    .ready_async (ready_async),
    .sw_rst_req  (sw_rst_req),
    .rst_out     (rst_out),
    .done        (done),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         at;
    logic [5:0] v;  // {rst_out, done, busy, timeout}
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev;

  always @(posedge clk) cyc++;

  // Monitor: every change of the output vector must match the next queued expectation.
  always @(negedge clk) begin
    logic [5:0] snap;
    exp_t       e;
    if (mon_en) begin
      snap = {rst_out, done, busy, timeout};
      if (snap !== prev) begin
        prev = snap;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change edge=%0d got=%b required=no change", cyc, snap);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || e.v !== snap) begin
            n_fail++;
            $display("FAIL transition got edge=%0d val=%b required edge=%0d val=%b",
                     cyc, snap, e.at, e.v);
          end
        end
      end
    end
  end

  task automatic push(input int at, input logic [2:0] r, input logic d, input logic b,
                      input logic t);
    exp_t e;
    e.at = at;
    e.v  = {r, d, b, t};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Bounded drain of outstanding expectations; leftovers count as failures.
  task automatic drain();
    int guard;
    exp_t e;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_transition got=none required edge=%0d val=%b", e.at, e.v);
    end
  endtask

  task automatic do_reset(input logic rdy);
    drain();
    mon_en      = 1'b0;
    async_clr   = 1'b1;
    sw_rst_req  = 1'b0;
    ready_async = rdy;
    @(negedge clk);
    check("reset_state", {rst_out, done, busy, timeout}, 6'b111_0_1_0);
    @(negedge clk);
    async_clr = 1'b0;
    cyc       = 0;
    prev      = {rst_out, done, busy, timeout};
    mon_en    = 1'b1;
  endtask

  initial begin
    #1;
    // Nominal release with ready stable, then software re-sequence from DONE.
    do_reset(1'b1);
    push(25, 3'b110, 1'b0, 1'b1, 1'b0);
    push(41, 3'b100, 1'b0, 1'b1, 1'b0);
    push(57, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(59);
    sw_rst_req = 1'b1;
    push(60, 3'b111, 1'b0, 1'b1, 1'b0);
    push(85, 3'b110, 1'b0, 1'b1, 1'b0);
    push(101, 3'b100, 1'b0, 1'b1, 1'b0);
    push(117, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(60);
    sw_rst_req = 1'b0;
    wait_cyc(125);

    // Ready loss mid-SEQ, then recovery.
    do_reset(1'b1);
    push(25, 3'b110, 1'b0, 1'b1, 1'b0);
    push(41, 3'b100, 1'b0, 1'b1, 1'b0);
    wait_cyc(44);
    ready_async = 1'b0;
    push(47, 3'b111, 1'b0, 1'b1, 1'b0);
    wait_cyc(60);
    ready_async = 1'b1;
    push(79, 3'b110, 1'b0, 1'b1, 1'b0);
    push(95, 3'b100, 1'b0, 1'b1, 1'b0);
    push(111, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(120);

`ifdef CDC_RST_SEQ_TIMEOUT_EN
    // Ready never arrives: timeout forces the sequence; sw request clears the flag.
    do_reset(1'b0);
    push(40, 3'b111, 1'b0, 1'b1, 1'b1);
    push(56, 3'b110, 1'b0, 1'b1, 1'b1);
    push(72, 3'b100, 1'b0, 1'b1, 1'b1);
    push(88, 3'b000, 1'b1, 1'b0, 1'b1);
    wait_cyc(94);
    sw_rst_req  = 1'b1;
    ready_async = 1'b1;
    push(95, 3'b111, 1'b0, 1'b1, 1'b0);
    push(120, 3'b110, 1'b0, 1'b1, 1'b0);
    push(136, 3'b100, 1'b0, 1'b1, 1'b0);
    push(152, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(95);
    sw_rst_req = 1'b0;
    wait_cyc(160);
`else
    // Ready low for a long time: stays in WAIT_RDY with everything held.
    do_reset(1'b0);
    wait_cyc(150);
    check("wait_rdy_hold", {rst_out, done, busy, timeout}, 6'b111_0_1_0);
    wait_cyc(200);
    ready_async = 1'b1;
    push(219, 3'b110, 1'b0, 1'b1, 1'b0);
    push(235, 3'b100, 1'b0, 1'b1, 1'b0);
    push(251, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(260);
`endif

    // async_clr between edges mid-SEQ takes effect without a clock edge.
    do_reset(1'b1);
    push(25, 3'b110, 1'b0, 1'b1, 1'b0);
    wait_cyc(30);
    mon_en = 1'b0;
    #2 async_clr = 1'b1;
    #1 check("async_clr_mid_seq", {rst_out, done, busy, timeout}, 6'b111_0_1_0);

    // sw request in HOLD extends it; simultaneous sw + ready loss in DONE; async_clr in DONE.
    do_reset(1'b1);
    wait_cyc(4);
    sw_rst_req = 1'b1;
    wait_cyc(5);
    sw_rst_req = 1'b0;
    push(30, 3'b110, 1'b0, 1'b1, 1'b0);
    push(46, 3'b100, 1'b0, 1'b1, 1'b0);
    push(62, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(70);
    sw_rst_req  = 1'b1;
    ready_async = 1'b0;
    push(71, 3'b111, 1'b0, 1'b1, 1'b0);
    wait_cyc(71);
    sw_rst_req = 1'b0;
    wait_cyc(100);
    ready_async = 1'b1;
    push(119, 3'b110, 1'b0, 1'b1, 1'b0);
    push(135, 3'b100, 1'b0, 1'b1, 1'b0);
    push(151, 3'b000, 1'b1, 1'b0, 1'b0);
    wait_cyc(155);
    drain();
    mon_en = 1'b0;
    #2 async_clr = 1'b1;
    #1 check("async_clr_in_done", {rst_out, done, busy, timeout}, 6'b111_0_1_0);

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
